// File: rtl/hull_fifo_pkg.sv
// Shared constants for hull_fifo: storage-type selectors and the per-instance
// FIFO configurations used by the F1 AMI-to-AXI4 read path.
package hull_fifo_pkg;

  localparam int FIFO_TYPE_REG  = 0;
  localparam int FIFO_TYPE_BRAM = 1;

  // Depth constants are log2 of the entry count (they feed LOG_DEPTH).
  localparam int F1_AMI2AXI4_RdPath_RdReqFIFO_Type   = FIFO_TYPE_REG;
  localparam int F1_AMI2AXI4_RdPath_RdReqFIFO_Depth  = 3;
  localparam int F1_AMI2AXI4_RdPath_RdRespFIFO_Type  = FIFO_TYPE_BRAM;
  localparam int F1_AMI2AXI4_RdPath_RdRespFIFO_Depth = 5;

endpackage

// File: rtl/hull_fifo_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port, no reset.
// A read of the address being written in the same cycle returns the old word.
module hull_fifo_ram
  import hull_fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LOG_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [LOG_DEPTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic [LOG_DEPTH-1:0] raddr_i,
  output logic [WIDTH-1:0]     rdata_o
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage arrays carry no reset; a reset term would stop the array
  // mapping onto RAM/flop-array primitives and nothing reads stale words anyway.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/hull_fifo.sv
// First-word-fall-through FIFO. Occupancy and flags are shared; TYPE picks a
// flop array or a synchronous-read RAM with a registered bypass head.
module hull_fifo
  import hull_fifo_pkg::*;
#(
  parameter int TYPE      = FIFO_TYPE_REG,
  parameter int WIDTH     = 32,
  parameter int LOG_DEPTH = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  input  logic             rdreq
);

  localparam int                   DEPTH      = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0]   FULL_COUNT = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   CNT_ONE    = (LOG_DEPTH+1)'(1);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE    = LOG_DEPTH'(1);

  logic [LOG_DEPTH:0]   count_q, count_d;
  logic [LOG_DEPTH-1:0] wptr_q, wptr_d;
  logic [LOG_DEPTH-1:0] rptr_q, rptr_d;
  logic                 push, pop;

  // Flags come from registered occupancy only, so wrreq/rdreq never reach them.
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);
  assign push  = wrreq && !full;
  assign pop   = rdreq && !empty;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  generate
    if (TYPE == FIFO_TYPE_REG) begin : g_reg
      logic [WIDTH-1:0] mem_q [DEPTH];

      always_ff @(posedge clock) begin
        if (push) mem_q[wptr_q] <= data;
      end

      assign q = mem_q[rptr_q];

    end else if (TYPE == FIFO_TYPE_BRAM) begin : g_bram
      logic [WIDTH-1:0] ram_rdata;
      logic [WIDTH-1:0] byp_q;
      logic             use_byp_q;
      logic             use_byp_d;

      // The RAM always prefetches the next head. When that head is the word
      // being written this edge (empty, or draining its last entry), the RAM
      // would return the old word, so the incoming data is captured instead.
      assign use_byp_d = push && (wptr_q == rptr_d);

      hull_fifo_ram #(
        .WIDTH     (WIDTH),
        .LOG_DEPTH (LOG_DEPTH)
      ) u_ram (
        .clk     (clock),
        .we_i    (push),
        .waddr_i (wptr_q),
        .wdata_i (data),
        .raddr_i (rptr_d),
        .rdata_o (ram_rdata)
      );

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) use_byp_q <= 1'b0;
        else          use_byp_q <= use_byp_d;
      end

      always_ff @(posedge clock) begin
        if (use_byp_d) byp_q <= data;
      end

      assign q = use_byp_q ? byp_q : ram_rdata;

    end else begin : g_bad_type
      $error("hull_fifo: unsupported TYPE %0d", TYPE);
    end
  endgenerate

endmodule

// File: tb/tb_hull_fifo.sv
// Directed bench for hull_fifo: a flop-array and a RAM-backed instance share
// one stimulus stream and are checked against the same hand-computed values.
module tb_hull_fifo;

  logic       clock;
  logic       reset_n;
  logic       wrreq;
  logic       rdreq;
  logic [7:0] data;

  logic       full0, empty0;
  logic [7:0] q0;
  logic       full1, empty1;
  logic [7:0] q1;

  int total = 0;
  int bad   = 0;

  hull_fifo #(.TYPE(0), .WIDTH(8), .LOG_DEPTH(2)) u_reg (
    .clock   (clock),
    .reset_n (reset_n),
    .wrreq   (wrreq),
    .data    (data),
    .full    (full0),
    .q       (q0),
    .empty   (empty0),
    .rdreq   (rdreq)
  );

  hull_fifo #(.TYPE(1), .WIDTH(8), .LOG_DEPTH(2)) u_bram (
    .clock   (clock),
    .reset_n (reset_n),
    .wrreq   (wrreq),
    .data    (data),
    .full    (full1),
    .q       (q1),
    .empty   (empty1),
    .rdreq   (rdreq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_st(input string tag, input logic e, input logic f,
                           input logic [7:0] qv, input bit chk_q);
    check({tag, ".reg.empty"},  {7'b0, empty0}, {7'b0, e});
    check({tag, ".reg.full"},   {7'b0, full0},  {7'b0, f});
    check({tag, ".bram.empty"}, {7'b0, empty1}, {7'b0, e});
    check({tag, ".bram.full"},  {7'b0, full1},  {7'b0, f});
    if (chk_q) begin
      check({tag, ".reg.q"},  q0, qv);
      check({tag, ".bram.q"}, q1, qv);
    end
  endtask

  // One clock with the given request lines; outputs are sampled 1 time unit
  // after the edge, and the request lines return to idle.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    wrreq = w;
    rdreq = r;
    data  = d;
    @(posedge clock);
    #1;
    wrreq = 1'b0;
    rdreq = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    wrreq   = 1'b0;
    rdreq   = 1'b0;
    data    = 8'h00;

    repeat (2) @(posedge clock);
    #1;
    expect_st("reset", 1'b1, 1'b0, 8'h00, 1'b0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    expect_st("idle", 1'b1, 1'b0, 8'h00, 1'b0);

    // Single push/pop
    cyc(1'b1, 1'b0, 8'h11);
    expect_st("push11", 1'b0, 1'b0, 8'h11, 1'b1);
    cyc(1'b0, 1'b1, 8'h00);
    expect_st("pop11", 1'b1, 1'b0, 8'h00, 1'b0);

    // Fill to capacity, overflow push ignored, drain in order
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 8'hA0 + 8'(i));
      expect_st($sformatf("fillA%0d", i), 1'b0, (i == 3), 8'hA0, 1'b1);
    end
    cyc(1'b1, 1'b0, 8'hFF);
    expect_st("overflow", 1'b0, 1'b1, 8'hA0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      expect_st($sformatf("drainA%0d", i), 1'b0, 1'b0, 8'hA1 + 8'(i), 1'b1);
    end
    cyc(1'b0, 1'b1, 8'h00);
    expect_st("drainA_last", 1'b1, 1'b0, 8'h00, 1'b0);

    // Simultaneous push/pop at count 2; pointers wrap past the end
    cyc(1'b1, 1'b0, 8'h01);
    cyc(1'b1, 1'b0, 8'h02);
    expect_st("cnt2", 1'b0, 1'b0, 8'h01, 1'b1);
    cyc(1'b1, 1'b1, 8'h03);
    expect_st("rw1", 1'b0, 1'b0, 8'h02, 1'b1);
    cyc(1'b1, 1'b1, 8'h03);
    expect_st("rw2", 1'b0, 1'b0, 8'h03, 1'b1);
    cyc(1'b1, 1'b1, 8'h03);
    expect_st("rw3", 1'b0, 1'b0, 8'h03, 1'b1);
    cyc(1'b0, 1'b1, 8'h00);
    expect_st("rw_pop1", 1'b0, 1'b0, 8'h03, 1'b1);
    cyc(1'b0, 1'b1, 8'h00);
    expect_st("rw_pop2", 1'b1, 1'b0, 8'h00, 1'b0);

    // Full FIFO with push+pop: only the pop takes effect
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'hB0 + 8'(i));
    expect_st("fullB", 1'b0, 1'b1, 8'hB0, 1'b1);
    cyc(1'b1, 1'b1, 8'h55);
    expect_st("full_rw", 1'b0, 1'b0, 8'hB1, 1'b1);
    cyc(1'b0, 1'b1, 8'h00);
    expect_st("full_rw_pop1", 1'b0, 1'b0, 8'hB2, 1'b1);
    cyc(1'b0, 1'b1, 8'h00);
    expect_st("full_rw_pop2", 1'b0, 1'b0, 8'hB3, 1'b1);
    cyc(1'b0, 1'b1, 8'h00);
    expect_st("full_rw_pop3", 1'b1, 1'b0, 8'h00, 1'b0);

    // Empty FIFO: lone read ignored, push+pop accepts only the push
    cyc(1'b0, 1'b1, 8'h00);
    expect_st("underflow", 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 8'h77);
    expect_st("empty_rw", 1'b0, 1'b0, 8'h77, 1'b1);
    cyc(1'b0, 1'b1, 8'h00);
    expect_st("empty_rw_pop", 1'b1, 1'b0, 8'h00, 1'b0);

    // Asynchronous reset mid-traffic, observed before any clock edge
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'hC0 + 8'(i));
    expect_st("fullC", 1'b0, 1'b1, 8'hC0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    expect_st("async_rst", 1'b1, 1'b0, 8'h00, 1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    expect_st("post_rst", 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h99);
    expect_st("post_rst_push", 1'b0, 1'b0, 8'h99, 1'b1);
    cyc(1'b0, 1'b1, 8'h00);
    expect_st("post_rst_pop", 1'b1, 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hull_fifo.md
# hull_fifo

Parameterised synchronous first-word-fall-through (show-ahead) FIFO used throughout the AMI/AXI4 glue to decouple arbiters from memory channels, e.g. read-request and read-response queues in the DDR read path. The head entry is visible on `q` whenever `empty` is low, so a consumer can inspect it and pop it in the same cycle. `TYPE` selects the storage implementation; every type has identical cycle-level behaviour at the ports.

## Interface
Parameters:
- `TYPE`, default 0: storage style. 0 = flop array (`FIFO_TYPE_REG`). 1 = synchronous-read RAM with prefetch/bypass (`FIFO_TYPE_BRAM`). Any other value is an elaboration error.
- `WIDTH`, default 32: entry width in bits (≥1).
- `LOG_DEPTH`, default 3: capacity is 2^`LOG_DEPTH` entries (≥1).

Ports:
- `clock`, in, 1: single clock; all state changes on the rising edge.
- `reset_n`, in, 1: asynchronous active-low reset.
- `wrreq`, in, 1: push `data` this cycle.
- `data`, in, `WIDTH`: entry to push.
- `full`, out, 1: FIFO holds 2^`LOG_DEPTH` entries.
- `q`, out, `WIDTH`: head entry, valid only while `empty`=0.
- `empty`, out, 1: FIFO holds zero entries.
- `rdreq`, in, 1: pop the head this cycle.

## Operation
- Occupancy counter `count` is `LOG_DEPTH`+1 bits wide. Write and read pointers are `LOG_DEPTH` bits wide and wrap naturally modulo depth.
- `empty` = (`count`==0) and `full` = (`count`==depth). Both are decoded from registered state only, with no combinational path from `wrreq`/`rdreq`.
- A push occurs when `wrreq` && !`full`. A `wrreq` while full is ignored: no overwrite and no error flag. This holds even if `rdreq` is high in the same cycle.
- A pop occurs when `rdreq` && !`empty`. An `rdreq` while empty is ignored, and no underflow occurs.
- Push and pop in the same cycle: both take effect, `count` is unchanged, and order is preserved.
- Write to an empty FIFO while `rdreq` is high: the push is accepted and the read is ignored.
- `q` presents the oldest unpopped entry. After a pop, `q` presents the next entry in the following cycle.
- Reset (`reset_n`=0, asynchronous): `count`=0, both pointers=0, `empty`=1, `full`=0. Storage contents are not reset.
- `q` is don't-care while `empty`=1, both at reset and afterwards. X is permitted. A pending prefetch register is cleared.
- Reset asserted mid-operation discards all entries immediately.

## Timing
- Write-to-visible latency is 1 cycle. After a push at edge N into an empty FIFO, `empty`=0 and `q`=pushed data during cycle N+1.
- Pop takes effect at the edge where `rdreq` && !`empty` is sampled. `q`/`empty` update in the following cycle.
- `full` rises in the cycle after the push that fills the last slot. It falls in the cycle after the first pop from full.
- `TYPE`=1 achieves the same 1-cycle visibility using a registered head. Required mechanisms:
  - a bypass path from `data` into the head register when the FIFO is empty or about to drain;
  - RAM read address driven by the next read pointer.
- No combinational path from `wrreq`/`data` to `q`/`empty`/`full` in either type.

## Structure
- Shared package constants:
  - `FIFO_TYPE_REG`=0 and `FIFO_TYPE_BRAM`=1.
  - Per-instance type/depth constants such as `F1_AMI2AXI4_RdPath_RdReqFIFO_Type`/`_Depth` and the RdResp equivalents, kept in the F1 types package.
- One sub-module: `hull_fifo_ram`, a simple dual-port RAM with parameters `WIDTH` and `LOG_DEPTH`, one write port and one synchronous read port, no reset. It is used only when `TYPE`=1.
- Both types are selected by a generate block inside `hull_fifo`. Counter and flag logic is shared between them.

## Test plan
Run each scenario for `TYPE` 0 and 1 with `WIDTH`=8, `LOG_DEPTH`=2 (depth 4):
- Reset then idle → `empty`=1 and `full`=0. Assert `reset_n`=0 mid-traffic → same flags within the cycle, with no clock edge needed.
- Push 0x11 into an empty FIFO → next cycle `empty`=0 and `q`=0x11. Pop → next cycle `empty`=1.
- Push 0xA0, 0xA1, 0xA2, 0xA3 → `full`=1 after the 4th. A 5th push of 0xFF is ignored. Pops return A0, A1, A2, A3 in order, then `empty`=1.
- FIFO at count 2 (0x01, 0x02): `wrreq`+`rdreq` together with 0x03 for 3 cycles →
  - count stays 2;
  - `q` sequence 0x01, 0x02, 0x03;
  - pointers wrap with no data loss.
- Full FIFO: `wrreq`+`rdreq` together with 0x55 → pop occurs, push ignored, next cycle `full`=0 and count=3.
- Empty FIFO: `rdreq` alone → no state change. `wrreq`+`rdreq` with 0x77 → next cycle `q`=0x77 and `empty`=0.
